// File: rtl/signal_event_fifo.sv
// ----------------------------------------------------------------------------
// signal_event_fifo
//
// Buffers timestamped pin-change events between the signal analyser and the
// SPI data sender. One event word is {time[31:0], pins[7:0]}. The sender
// drains one word per 5-byte SPI frame. Bursts of pin activity are absorbed
// here. A write that finds no free slot is dropped, and the drop is reported
// through a sticky overflow flag and a saturating dropped_count.
//
// Handshake: the write side is a strobe with no back-pressure. A word offered
// with wr_valid=1 is either stored or dropped in that same cycle. The read
// side is first-word-fall-through. While rd_valid=1, rd_data holds the oldest
// word. rd_ack=1 in a cycle with rd_valid=1 pops that word at the clock edge.
// rd_ack while rd_valid=0 is ignored.
//
// Optional feature (macro SIGNAL_FIFO_DROP_MARKER_EN): after a run of drops,
// an in-band marker word {16'hFFFF, dropped_count, 8'h00} is inserted at the
// first free slot. This marks the position of the loss in the stream.
//
// Ports:
//   clk           system clock
//   rst           asynchronous, active-low reset
//   wr_valid      single-cycle event strobe from the analyser
//   wr_data       event word, sampled when wr_valid=1
//   rd_data       registered head-of-queue word
//   rd_valid      FIFO non-empty
//   rd_ack        sender latched rd_data; pop the head
//   count         number of stored words, 0..2^DEPTH_LOG2
//   full          count == 2^DEPTH_LOG2
//   overflow      sticky: a write was dropped since the last clear
//   clr_overflow  clears overflow and dropped_count
//   dropped_count saturating count of dropped writes
// ----------------------------------------------------------------------------
module signal_event_fifo #(
    parameter int DATA_W     = 40,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ack,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  overflow,
    input  logic                  clr_overflow,
    output logic [15:0]           dropped_count
);

    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] ONE       = (DEPTH_LOG2 + 1)'(1);

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic [DEPTH_LOG2:0] rd_ptr_next;
    logic [DEPTH_LOG2:0] count_next;
    logic [DATA_W-1:0]   push_data;
    logic [DATA_W-1:0]   head_next;
    logic                pop;
    logic                slot_free;
    logic                marker_write;
    logic                push;
    logic                drop;

    assign full      = (count == DEPTH_CNT);
    assign pop       = rd_ack && rd_valid;
    // A slot is available if not full, or if the head leaves this same cycle.
    assign slot_free = !full || pop;

`ifdef SIGNAL_FIFO_DROP_MARKER_EN
    logic [DATA_W-1:0] marker_word;
    // A non-zero dropped_count means the current drop run is still unmarked.
    // Writing a marker clears the count, and clr_overflow also cancels it.
    assign marker_write = (dropped_count != 16'd0) && slot_free;
    assign marker_word  = DATA_W'({16'hFFFF, dropped_count, 8'h00});
    assign push_data    = marker_write ? marker_word : wr_data;
`else
    assign marker_write = 1'b0;
    assign push_data    = wr_data;
`endif

    // The marker takes the free slot ahead of a concurrent event, so that event is dropped.
    assign push = slot_free && (wr_valid || marker_write);
    assign drop = wr_valid && !(slot_free && !marker_write);

    assign rd_ptr_next = pop ? (rd_ptr + ONE) : rd_ptr;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + ONE;
            2'b01:   count_next = count - ONE;
            default: count_next = count;
        endcase
    end

    // Next registered head. If the slot being written is the new head, the
    // FIFO is empty after this cycle's pop, so bypass the incoming word.
    always_comb begin
        head_next = mem[rd_ptr_next[DEPTH_LOG2-1:0]];
        if (push && (wr_ptr == rd_ptr_next)) begin
            head_next = push_data;
        end
    end

    // Storage has no reset. Contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE;
            end
            rd_ptr   <= rd_ptr_next;
            count    <= count_next;
            rd_valid <= (count_next != '0);
            if (count_next != '0) begin
                rd_data <= head_next;
            end
        end
    end

    // A drop in the same cycle as a clear (or as a marker write) starts a new
    // run at 1 instead of being lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow      <= 1'b0;
            dropped_count <= 16'd0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
                if (clr_overflow || marker_write) begin
                    dropped_count <= 16'd1;
                end else if (dropped_count != 16'hFFFF) begin
                    dropped_count <= dropped_count + 16'd1;
                end
            end else begin
                if (clr_overflow) begin
                    overflow <= 1'b0;
                end
                if (clr_overflow || marker_write) begin
                    dropped_count <= 16'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_signal_event_fifo.sv
module tb_signal_event_fifo;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic [39:0] wr_data;
    logic [39:0] rd_data;
    logic        rd_valid;
    logic        rd_ack;
    logic [4:0]  count;
    logic        full;
    logic        overflow;
    logic        clr_overflow;
    logic [15:0] dropped_count;

    int          n_vec = 0;
    int          n_err = 0;
    logic [39:0] exp_q[$];
    int          m_count = 0;
    int          m_dc = 0;

    signal_event_fifo #(.DATA_W(40), .DEPTH_LOG2(4)) dut (
        .clk          (clk),
        .rst          (rst_n),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ack       (rd_ack),
        .count        (count),
        .full         (full),
        .overflow     (overflow),
        .clr_overflow (clr_overflow),
        .dropped_count(dropped_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] fill_word(input int i);
        logic [39:0] w;
        w = {32'(256 + i), 8'(i * 7 + 3)};
        return w;
    endfunction

    // Driver: apply one cycle of inputs and record the expected stored words.
    task automatic cycle(input logic wv, input logic [39:0] wd, input logic ack, input logic clr);
        bit p, slot, mw, acc, drp;
        wr_valid     = wv;
        wr_data      = wd;
        rd_ack       = ack;
        clr_overflow = clr;
        p    = ack && (m_count > 0);
        slot = (m_count < 16) || p;
`ifdef SIGNAL_FIFO_DROP_MARKER_EN
        mw = (m_dc != 0) && slot;
`else
        mw = 1'b0;
`endif
        if (mw) exp_q.push_back({16'hFFFF, 16'(m_dc), 8'h00});
        acc = wv && slot && !mw;
        drp = wv && !acc;
        if (acc) exp_q.push_back(wd);
        m_count = m_count + ((mw || acc) ? 1 : 0) - (p ? 1 : 0);
        if (drp) m_dc = (clr || mw) ? 1 : ((m_dc < 65535) ? m_dc + 1 : m_dc);
        else if (clr || mw) m_dc = 0;
        @(posedge clk);
        #1;
        wr_valid     = 1'b0;
        rd_ack       = 1'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 40'h0, 1'b1, 1'b0);
    endtask

    // Monitor/scoreboard: every accepted pop must deliver the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ack) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 64'(rd_valid), 64'(0));
            end else begin
                check("pop_data", 64'(rd_data), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        wr_valid     = 1'b0;
        wr_data      = '0;
        rd_ack       = 1'b0;
        clr_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_count", 64'(count), 64'(0));
        check("rst_full", 64'(full), 64'(0));
        check("rst_rd_valid", 64'(rd_valid), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_dropped", 64'(dropped_count), 64'(0));
        check("rst_rd_data", 64'(rd_data), 64'(0));
        rst_n = 1'b1;
        cycle(1'b0, 40'h0, 1'b0, 1'b0);

        // Three writes, then ordered read-back.
        cycle(1'b1, 40'h00000001_A5, 1'b0, 1'b0);
        check("first_rd_valid", 64'(rd_valid), 64'(1));
        check("first_rd_data", 64'(rd_data), 64'h00000001_A5);
        cycle(1'b1, 40'h00000002_5A, 1'b0, 1'b0);
        cycle(1'b1, 40'h00000003_FF, 1'b0, 1'b0);
        check("three_count", 64'(count), 64'(3));
        check("three_rd_valid", 64'(rd_valid), 64'(1));
        check("three_rd_data", 64'(rd_data), 64'h00000001_A5);
        drain(3);
        check("drained_rd_valid", 64'(rd_valid), 64'(0));
        check("drained_count", 64'(count), 64'(0));

        // Fill to 16, then one dropped write.
        for (int i = 0; i < 16; i++) cycle(1'b1, fill_word(i), 1'b0, 1'b0);
        check("fill_count", 64'(count), 64'(16));
        check("fill_full", 64'(full), 64'(1));
        check("fill_overflow", 64'(overflow), 64'(0));
        cycle(1'b1, 40'hDEADBEEF_01, 1'b0, 1'b0);
        check("drop_full", 64'(full), 64'(1));
        check("drop_overflow", 64'(overflow), 64'(1));
        check("drop_count1", 64'(dropped_count), 64'(1));
        check("drop_count_words", 64'(count), 64'(16));
`ifndef SIGNAL_FIFO_DROP_MARKER_EN
        // Full + write + pop: both happen, nothing dropped.
        cycle(1'b1, 40'hCAFE0000_77, 1'b1, 1'b0);
        check("fullwp_count", 64'(count), 64'(16));
        check("fullwp_full", 64'(full), 64'(1));
        check("fullwp_dropped", 64'(dropped_count), 64'(1));
`endif
        cycle(1'b0, 40'h0, 1'b0, 1'b1);
        check("clr_overflow", 64'(overflow), 64'(0));
        check("clr_dropped", 64'(dropped_count), 64'(0));
        drain(16);
        check("drain16_count", 64'(count), 64'(0));
        check("drain16_rd_valid", 64'(rd_valid), 64'(0));

        // Empty + write + ack: ack ignored, write accepted.
        cycle(1'b1, 40'h12345678_9A, 1'b1, 1'b0);
        check("ew_count", 64'(count), 64'(1));
        check("ew_rd_valid", 64'(rd_valid), 64'(1));
        check("ew_overflow", 64'(overflow), 64'(0));
        check("ew_rd_data", 64'(rd_data), 64'h12345678_9A);
        drain(1);

        // Drop 3, clear, then a clear coinciding with a drop.
        for (int i = 0; i < 16; i++) cycle(1'b1, fill_word(i + 40), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 40'hBAD00000_00, 1'b0, 1'b0);
        check("drop3_dropped", 64'(dropped_count), 64'(3));
        check("drop3_overflow", 64'(overflow), 64'(1));
        cycle(1'b0, 40'h0, 1'b0, 1'b1);
        check("clr3_overflow", 64'(overflow), 64'(0));
        check("clr3_dropped", 64'(dropped_count), 64'(0));
        cycle(1'b1, 40'hBAD00000_01, 1'b0, 1'b1);
        check("clrdrop_overflow", 64'(overflow), 64'(1));
        check("clrdrop_dropped", 64'(dropped_count), 64'(1));
        cycle(1'b0, 40'h0, 1'b0, 1'b1);
        drain(16);
        check("drain_b_count", 64'(count), 64'(0));

`ifdef SIGNAL_FIFO_DROP_MARKER_EN
        // Fill, drop 2, pop 1: the marker takes the freed slot.
        for (int i = 0; i < 16; i++) cycle(1'b1, fill_word(i + 80), 1'b0, 1'b0);
        cycle(1'b1, 40'hBAD00000_02, 1'b0, 1'b0);
        cycle(1'b1, 40'hBAD00000_03, 1'b0, 1'b0);
        check("mk_dropped2", 64'(dropped_count), 64'(2));
        drain(1);
        check("mk_dropped0", 64'(dropped_count), 64'(0));
        check("mk_overflow", 64'(overflow), 64'(1));
        check("mk_count", 64'(count), 64'(16));
        drain(15);
        check("mk_word", 64'(rd_data), 64'hFFFF0002_00);
        drain(1);
        check("mk_empty", 64'(rd_valid), 64'(0));
        cycle(1'b0, 40'h0, 1'b0, 1'b1);
`endif

        // Reset in the middle of a burst, asserted between clock edges.
        cycle(1'b1, 40'h0000AAAA_01, 1'b0, 1'b0);
        cycle(1'b1, 40'h0000AAAA_02, 1'b0, 1'b0);
        cycle(1'b1, 40'h0000AAAA_03, 1'b0, 1'b0);
        wr_valid = 1'b1;
        wr_data  = 40'h0000AAAA_04;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_count", 64'(count), 64'(0));
        check("arst_rd_valid", 64'(rd_valid), 64'(0));
        check("arst_full", 64'(full), 64'(0));
        check("arst_overflow", 64'(overflow), 64'(0));
        check("arst_dropped", 64'(dropped_count), 64'(0));
        check("arst_rd_data", 64'(rd_data), 64'(0));
        wr_valid = 1'b0;
        exp_q.delete();
        m_count = 0;
        m_dc    = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 40'h0, 1'b1, 1'b0);
        check("post_rst_count", 64'(count), 64'(0));
        check("post_rst_rd_valid", 64'(rd_valid), 64'(0));
        cycle(1'b1, 40'h0000BBBB_05, 1'b0, 1'b0);
        check("post_rst_write", 64'(rd_data), 64'h0000BBBB_05);
        drain(1);

        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/signal_event_fifo.md
Name: signal_event_fifo

Overview:
- Buffers timestamped pin-change events between the signal analyser and the SPI data sender.
- The analyser produces one 40-bit event word: {time[31:0], pins[7:0]}.
- The sender drains one word per 5-byte SPI frame.
- The FIFO absorbs bursts of pin activity so that events are not overwritten while a frame is in flight. Overflow is reported and counted.

Parameters:
- DATA_W, 40: event word width; bits [39:8] are time, bits [7:0] are pin values.
- DEPTH_LOG2, 4: log2 of storage depth (default 16 entries).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- wr_valid  in  1  analyser presents a new event this cycle (single-cycle strobe).
- wr_data  in  DATA_W  event word, sampled when wr_valid=1.
- rd_data  out  DATA_W  head-of-queue word (first-word-fall-through); valid only when rd_valid=1.
- rd_valid  out  1  FIFO non-empty; rd_data holds the oldest word.
- rd_ack  in  1  sender has latched rd_data; pop the head.
- count  out  DEPTH_LOG2+1  number of stored words, 0..2^DEPTH_LOG2.
- full  out  1  count == 2^DEPTH_LOG2.
- overflow  out  1  sticky: at least one write was dropped since the last clear.
- clr_overflow  in  1  clears overflow and dropped_count.
- dropped_count  out  16  saturating count of dropped writes.

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0.
  - Affected outputs: count, full, rd_valid, overflow, dropped_count, rd_data.
  - Read and write pointers are 0.
  - Storage contents are don't-care.
- Storage and pointers:
  - Storage is a circular buffer of 2^DEPTH_LOG2 entries.
  - Pointers are DEPTH_LOG2+1 bits; the extra MSB distinguishes full from empty.
  - Pointers wrap modulo 2^(DEPTH_LOG2+1).
- Write:
  - Accepted when wr_valid=1 and (full=0 or a pop occurs the same cycle).
  - The word is stored at wr_ptr, and wr_ptr increments on the next clock edge.
- Pop:
  - Occurs when rd_ack=1 and rd_valid=1.
  - rd_ack while rd_valid=0 is ignored and has no side effects.
- Latency:
  - A write into an empty FIFO gives rd_valid=1 with rd_data equal to that word one cycle later.
  - After a pop, the next word (if any) is presented on the following cycle.
  - rd_data is registered.
- Count:
  - count and full update on the clock edge after the push/pop.
  - Push and pop in the same cycle leave count unchanged.
- Full + write + pop in the same cycle: both happen, nothing is dropped, full stays 1.
- Empty + write + rd_ack in the same cycle: the ack is ignored and the write is accepted.
- Drop:
  - Occurs when wr_valid=1, full=1 and there is no pop.
  - The word is discarded and overflow is set to 1.
  - dropped_count increments, saturating at 16'hFFFF.
- clr_overflow:
  - Clears overflow and dropped_count on the next edge.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, dropped_count=1.
- Stored data is never modified by clr_overflow.
- Reset mid-operation discards all contents immediately. rd_valid drops asynchronously.

Optional Feature:
- Macro: SIGNAL_FIFO_DROP_MARKER_EN.
- Without the macro: drops are reported only via overflow and dropped_count. The stream contains only real events.
- With the macro:
  - A marker is pending whenever dropped_count is non-zero and the current drop run has not yet been marked.
  - The marker is written on the first cycle with a free slot (full=0, or a pop that cycle).
  - The marker has priority over wr_valid. A concurrent event word is dropped and starts a new drop run at count 1.
  - Marker word: time field = {16'hFFFF, dropped_count[15:0]}, pin field = 8'h00.
  - Writing a marker resets dropped_count to 0 but leaves overflow set.
  - The host therefore sees an in-band gap indication at the exact position of the loss.

Test Plan:
- Reset, then 3 writes of 40'h00000001_A5, 40'h00000002_5A, 40'h00000003_FF with rd_ack low -> count=3, rd_valid=1, rd_data=40'h00000001_A5. Three acks return the words in order, then rd_valid=0 and count=0.
- Fill 16 entries, then a 17th write with no ack -> full=1, overflow=1, dropped_count=1. Drained contents are exactly the first 16 words.
- With full=1, assert wr_valid and rd_ack together -> count stays 16, no drop, and the new word appears last when drained.
- Empty FIFO, wr_valid and rd_ack in the same cycle -> count=1 next cycle, rd_valid=1, overflow=0.
- Fill, then drop 3 writes, then pulse clr_overflow -> overflow=0, dropped_count=0. A clr_overflow coinciding with a drop -> overflow=1, dropped_count=1.
- With SIGNAL_FIFO_DROP_MARKER_EN: fill, drop 2, pop 1 -> next stored word is 40'hFFFF0002_00, and dropped_count returns to 0.
- Any scenario with rst asserted mid-burst -> all outputs 0 asynchronously, and the FIFO is empty after release.
